// File: rtl/cr_structs.sv
// Shared AXI4-Stream datapath types and the outbound master state encoding.
package cr_structs;

  localparam int unsigned AXI4S_DATA_W = 64;
  localparam int unsigned AXI4S_ID_W   = 8;
  localparam int unsigned AXI4S_USER_W = 8;
  localparam int unsigned AXI4S_STRB_W = AXI4S_DATA_W / 8;

  typedef struct packed {
    logic                    tvalid;
    logic                    tlast;
    logic [AXI4S_ID_W-1:0]   tid;
    logic [AXI4S_STRB_W-1:0] tstrb;
    logic [AXI4S_USER_W-1:0] tuser;
    logic [AXI4S_DATA_W-1:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } ob_state_e;

endpackage

// File: rtl/cr_axi4s_skid.sv
// Two-entry skid buffer between a show-ahead FIFO and an AXI4-Stream master port.
// The tvalid bit of each stored beat doubles as that entry's occupancy flag.
module cr_axi4s_skid
  import cr_structs::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ib_empty,
  input  axi4s_dp_bus_t ib_in,
  output logic          ib_rd,
  output axi4s_dp_bus_t ob_out,
  input  logic          ob_ready,
  output logic          buf_empty
);

  axi4s_dp_bus_t main_q, main_d;
  axi4s_dp_bus_t skid_q, skid_d;
  logic          run_q, run_d;

  // Pop only when skid can absorb a stalled beat; run_q keeps ib_rd low through reset.
  assign ib_rd     = run_q & ~ib_empty & ~skid_q.tvalid;
  assign ob_out    = main_q;
  assign buf_empty = ~main_q.tvalid & ~skid_q.tvalid;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    run_d  = 1'b1;
    if (!main_q.tvalid || ob_ready) begin
      if (skid_q.tvalid) begin
        main_d        = skid_q;
        skid_d.tvalid = 1'b0;
      end else if (ib_rd) begin
        main_d        = ib_in;
        main_d.tvalid = 1'b1;
      end else begin
        main_d.tvalid = 1'b0;
      end
    end else if (ib_rd) begin
      skid_d        = ib_in;
      skid_d.tvalid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      run_q  <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/cr_axi4s_ob_mstr.sv
// Outbound AXI4-Stream master: drains a show-ahead FIFO through a skid buffer,
// tracks frame boundaries and keeps frame and stall statistics.
module cr_axi4s_ob_mstr
  import cr_structs::*;
#(
  parameter int unsigned N_STALL_WIDTH = 16,
  parameter int unsigned N_FRM_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ib_empty,
  input  axi4s_dp_bus_t            ib_in,
  output logic                     ib_rd,
  output axi4s_dp_bus_t            axi4s_ob_out,
  input  axi4s_dp_rdy_t            axi4s_ob_in,
  output logic [N_FRM_WIDTH-1:0]   frm_cnt,
  output logic [N_STALL_WIDTH-1:0] stall_cnt,
  output logic                     ob_idle
);

  ob_state_e                state_q, state_d;
  logic [N_FRM_WIDTH-1:0]   frm_cnt_q, frm_cnt_d;
  logic [N_STALL_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                     buf_empty;
  logic                     beat_acc;
  logic                     beat_stall;

  cr_axi4s_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .ib_empty  (ib_empty),
    .ib_in     (ib_in),
    .ib_rd     (ib_rd),
    .ob_out    (axi4s_ob_out),
    .ob_ready  (axi4s_ob_in.tready),
    .buf_empty (buf_empty)
  );

  assign beat_acc   = axi4s_ob_out.tvalid & axi4s_ob_in.tready;
  assign beat_stall = axi4s_ob_out.tvalid & ~axi4s_ob_in.tready;

  // A single-beat frame (tlast while IDLE) leaves the state untouched.
  always_comb begin
    state_d     = state_q;
    frm_cnt_d   = frm_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (beat_acc) begin
      if (axi4s_ob_out.tlast) begin
        state_d   = IDLE;
        frm_cnt_d = frm_cnt_q + N_FRM_WIDTH'(1);
      end else begin
        state_d = IN_FRAME;
      end
    end
    if (beat_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + N_STALL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frm_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frm_cnt_q   <= frm_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign frm_cnt   = frm_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign ob_idle   = buf_empty & (state_q == IDLE);

endmodule

// File: tb/tb_cr_axi4s_ob_mstr.sv
// Scoreboard bench for cr_axi4s_ob_mstr: a modelled show-ahead FIFO feeds the DUT,
// expected beats are queued at issue time and a monitor checks every accepted beat.
module tb_cr_axi4s_ob_mstr;
   import cr_structs::*;

   localparam int FW = 32;
   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          ibEmpty = 1'b1;
   axi4s_dp_bus_t ibIn = '0;
   logic          ibRd;
   axi4s_dp_bus_t obOut;
   axi4s_dp_rdy_t obIn = '0;
   logic [FW-1:0] frmCnt;
   logic [SW-1:0] stallCnt;
   logic          obIdle;

   cr_axi4s_ob_mstr #(.N_STALL_WIDTH(SW), .N_FRM_WIDTH(FW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ib_empty     (ibEmpty),
      .ib_in        (ibIn),
      .ib_rd        (ibRd),
      .axi4s_ob_out (obOut),
      .axi4s_ob_in  (obIn),
      .frm_cnt      (frmCnt),
      .stall_cnt    (stallCnt),
      .ob_idle      (obIdle)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   axi4s_dp_bus_t srcQ[$];
   axi4s_dp_bus_t expQ[$];
   int            errors = 0;
   int            checks = 0;
   int            cycle = 0;
   logic          popPending = 1'b0;
   logic          prevStall = 1'b0;
   axi4s_dp_bus_t prevOut = '0;
   int            stallCycles = 0;
   bit            readyRandom = 1'b0;
   bit            readyLevel = 1'b1;
   logic [SW-1:0] expStall = '0;
   int            firstRdCycle = -1;
   int            firstValidCycle = -1;
   int            validCount = 0;
   int            rdCount = 0;
   int            beatSeq = 0;

   // Single comparison point: every check funnels through here
   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Queue a frame of nBeats into the upstream FIFO model and the scoreboard
   task automatic applyStimulus(input int nBeats);
      axi4s_dp_bus_t b;
      for (int i = 0; i < nBeats; i++) begin
         b        = '0;
         b.tvalid = 1'b1;
         b.tlast  = (i == nBeats - 1);
         b.tid    = 8'(beatSeq);
         b.tstrb  = 8'(beatSeq * 7 + 1);
         b.tuser  = 8'(beatSeq) ^ 8'h5a;
         b.tdata  = {32'(beatSeq), 32'ha5a5_0000 ^ 32'(beatSeq)};
         srcQ.push_back(b);
         expQ.push_back(b);
         beatSeq++;
      end
   endtask

   // Wait (bounded) until everything queued has been delivered and the DUT is idle
   task automatic waitIdle(input int budget);
      int n = 0;
      while (!(obIdle && srcQ.size() == 0 && expQ.size() == 0) && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      checkOutput("wait_idle", 128'(obIdle && srcQ.size() == 0 && expQ.size() == 0), 128'd1);
   endtask

   // Upstream FIFO model and tready driver, updated just after each rising edge
   always @(posedge clk) begin
      #1;
      if (popPending && srcQ.size() > 0) void'(srcQ.pop_front());
      ibEmpty = (srcQ.size() == 0);
      ibIn    = ibEmpty ? '0 : srcQ[0];
      if (stallCycles > 0) begin
         obIn.tready = 1'b0;
         stallCycles--;
      end else if (readyRandom) begin
         obIn.tready = 1'($urandom_range(0, 1));
      end else begin
         obIn.tready = readyLevel;
      end
   end

   // Monitor on the falling edge: scoreboard pops, stability and protocol checks
   always @(negedge clk) begin
      cycle++;
      if (!rst_n) begin
         prevStall  = 1'b0;
         popPending = 1'b0;
      end else begin
         checkOutput("rd_while_empty", 128'(ibRd & ibEmpty), 128'd0);
         if (prevStall) checkOutput("stable_while_stalled", obOut, prevOut);
         if (ibRd) begin
            rdCount++;
            if (firstRdCycle < 0) firstRdCycle = cycle;
         end
         if (obOut.tvalid) begin
            validCount++;
            if (firstValidCycle < 0) firstValidCycle = cycle;
         end
         if (obOut.tvalid && obIn.tready) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_beat: got %0h, expected no beat", obOut);
            end else begin
               checkOutput("beat_data", obOut, expQ.pop_front());
            end
         end
         if (obOut.tvalid && !obIn.tready && expStall != '1) expStall++;
         prevStall  = obOut.tvalid && !obIn.tready;
         prevOut    = obOut;
         popPending = ibRd;
      end
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      int n;
      #1 rst_n = 1'b0;
      #2;
      checkOutput("reset_out", obOut, 128'd0);
      checkOutput("reset_ib_rd", 128'(ibRd), 128'd0);
      checkOutput("reset_frm_cnt", frmCnt, 128'd0);
      checkOutput("reset_stall_cnt", stallCnt, 128'd0);
      checkOutput("reset_ob_idle", 128'(obIdle), 128'd1);
      @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
      @(negedge clk); @(negedge clk); #1;

      $display("[TB] back-to-back 8-beat frame");
      firstRdCycle = -1; firstValidCycle = -1; validCount = 0;
      applyStimulus(8);
      waitIdle(100);
      checkOutput("first_beat_latency", 128'(firstValidCycle - firstRdCycle), 128'd1);
      checkOutput("valid_cycles", 128'(validCount), 128'd8);
      checkOutput("frm_cnt_one", frmCnt, 128'd1);

      $display("[TB] 5-cycle stall mid-frame");
      applyStimulus(6);
      n = 0;
      while (expQ.size() > 4 && n < 50) begin @(negedge clk); #1; n++; end
      checkOutput("stall_setup", 128'(expQ.size()), 128'd4);
      stallCycles = 5;
      repeat (5) begin @(negedge clk); #1; end
      checkOutput("stall_tready_low", 128'(obIn.tready), 128'd0);
      checkOutput("ib_rd_skid_full", 128'(ibRd), 128'd0);
      checkOutput("two_buffered", 128'({dut.u_skid.main_q.tvalid, dut.u_skid.skid_q.tvalid}), 128'd3);
      waitIdle(100);
      checkOutput("stall_cnt_five", stallCnt, 128'd5);
      checkOutput("frm_cnt_two", frmCnt, 128'd2);

      $display("[TB] random tready, 100 frames x 10 beats");
      readyRandom = 1'b1;
      for (int f = 0; f < 100; f++) applyStimulus(10);
      waitIdle(20000);
      readyRandom = 1'b0;
      checkOutput("frm_cnt_random", frmCnt, 128'd102);
      checkOutput("stall_cnt_model", stallCnt, expStall);

      $display("[TB] counter wrap and saturation");
      @(negedge clk); #1;
      force dut.frm_cnt_q = '1;
      #1 release dut.frm_cnt_q;
      checkOutput("frm_cnt_preload", frmCnt, {FW{1'b1}});
      applyStimulus(1);
      waitIdle(50);
      checkOutput("frm_cnt_wrap", frmCnt, 128'd0);
      checkOutput("single_beat_idle", 128'(dut.state_q), 128'(IDLE));
      @(negedge clk); #1;
      force dut.stall_cnt_q = '1;
      #1 release dut.stall_cnt_q;
      expStall = '1;
      stallCycles = 3;
      applyStimulus(1);
      waitIdle(50);
      checkOutput("stall_cnt_saturate", stallCnt, {SW{1'b1}});

      $display("[TB] asynchronous reset mid-frame");
      applyStimulus(5);
      n = 0;
      while (expQ.size() > 4 && n < 50) begin @(negedge clk); #1; n++; end
      readyLevel = 1'b0;
      repeat (3) begin @(negedge clk); #1; end
      checkOutput("pre_reset_buffered", 128'({dut.u_skid.main_q.tvalid, dut.u_skid.skid_q.tvalid}), 128'd3);
      checkOutput("pre_reset_in_frame", 128'(obIdle), 128'd0);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("async_tvalid", 128'(obOut.tvalid), 128'd0);
      checkOutput("async_out", obOut, 128'd0);
      checkOutput("async_ib_rd", 128'(ibRd), 128'd0);
      checkOutput("async_frm_cnt", frmCnt, 128'd0);
      checkOutput("async_stall_cnt", stallCnt, 128'd0);
      checkOutput("async_ob_idle", 128'(obIdle), 128'd1);
      srcQ.delete();
      expQ.delete();
      expStall = '0;
      readyLevel = 1'b1;
      @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
      @(negedge clk); #1;
      applyStimulus(3);
      waitIdle(50);
      checkOutput("post_reset_frm_cnt", frmCnt, 128'd1);
      checkOutput("post_reset_stall_cnt", stallCnt, 128'd0);

      $display("[TB] empty FIFO with toggling tready");
      validCount = 0; rdCount = 0;
      repeat (20) begin
         @(negedge clk); #1;
         readyLevel = ~readyLevel;
      end
      readyLevel = 1'b1;
      checkOutput("empty_no_valid", 128'(validCount), 128'd0);
      checkOutput("empty_no_rd", 128'(rdCount), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cr_axi4s_ob_mstr.md
CR_AXI4S_OB_MSTR -- requirements
Module: cr_axi4s_ob_mstr

Interface
REQ-001 Parameter: N_STALL_WIDTH, default 16, width of the saturating stall counter.
REQ-002 Parameter: N_FRM_WIDTH, default 32, width of the wrapping frame counter.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ib_empty  input  1  upstream show-ahead FIFO empty; ib_in is valid whenever ib_empty=0.
REQ-006 ib_in  input  axi4s_dp_bus_t  head entry of the upstream FIFO, e.g. tlvp_ob.
REQ-007 ib_rd  output  1  pops the head entry in the same cycle.
REQ-008 axi4s_ob_out  output  axi4s_dp_bus_t  AXI4-Stream master beat (tvalid, tlast, tid, tstrb, tuser, tdata).
REQ-009 axi4s_ob_in  input  axi4s_dp_rdy_t  downstream tready.
REQ-010 frm_cnt  output  N_FRM_WIDTH  count of frames sent (tlast beats accepted).
REQ-011 stall_cnt  output  N_STALL_WIDTH  count of cycles with tvalid=1 and tready=0.
REQ-012 ob_idle  output  1  no beat is buffered and the FSM is in IDLE.

Function
REQ-013 The block SHALL hold a 2-entry skid buffer (main + skid registers); axi4s_ob_out SHALL be driven only from registers.
REQ-014 ib_rd SHALL be 1 iff ib_empty=0 and the skid entry is empty; it SHALL be computed from registered state only, with no combinational path from tready.
REQ-015 A popped beat SHALL appear on axi4s_ob_out exactly 1 cycle after ib_rd=1 when the main entry is empty or is being accepted.
REQ-016 A beat is transferred when tvalid=1 and tready=1; sustained throughput SHALL be 1 beat/cycle with continuous tready=1.
REQ-017 On tready=0 with the main entry full, a popped beat SHALL be stored in skid; once tready returns, main<-skid and beat order SHALL be preserved.
REQ-018 While tvalid=1 and tready=0, all axi4s_ob_out fields SHALL remain stable.
REQ-019 FSM states: IDLE, IN_FRAME.
REQ-020 IDLE->IN_FRAME on an accepted beat with tlast=0; IN_FRAME->IDLE on an accepted beat with tlast=1; a single-beat frame (tlast=1 in IDLE) stays in IDLE.
REQ-021 frm_cnt SHALL increment on every accepted tlast beat and wrap from all-ones to 0.
REQ-022 stall_cnt SHALL increment on every cycle with tvalid=1 and tready=0, saturating at all-ones.
REQ-023 tready while tvalid=0 SHALL have no effect.
REQ-024 A simultaneous pop and acceptance with skid empty SHALL load main directly, keeping occupancy at 1.
REQ-025 ib_rd SHALL never assert while ib_empty=1.

Reset
REQ-026 On rst_n=0 asynchronously: both buffer entries invalid, tvalid=0, ib_rd=0, FSM=IDLE, frm_cnt=0, stall_cnt=0, ob_idle=1; data fields 0.
REQ-027 Reset mid-frame SHALL discard buffered beats; after release, the first beat output SHALL be treated as a frame start.

Structure
REQ-028 axi4s_dp_bus_t and axi4s_dp_rdy_t SHALL come from the shared cr_structs package; the FSM state enum SHALL be declared in a shared package as the type for ob state.
REQ-029 The skid buffer SHALL be a sub-module, cr_axi4s_skid, instantiated once; the FSM and counters stay at the top level.

Verification
REQ-030 tready=1 constantly, 8-beat frame pushed back-to-back -> 8 consecutive tvalid cycles starting 1 cycle after the first ib_rd, frm_cnt 0->1, ob_idle=1 after the last beat.
REQ-031 tready=0 for 5 cycles mid-frame with FIFO non-empty -> exactly 2 beats buffered, ib_rd low after skid fills, stall_cnt=5, no beat loss or reorder, data stable.
REQ-032 Random tready (50%) over 1000 beats and 100 frames -> output matches the input sequence, frm_cnt=100.
REQ-033 frm_cnt preloaded via force to all-ones, one tlast beat -> frm_cnt=0; stall_cnt forced to all-ones plus a stall -> stays all-ones.
REQ-034 rst_n pulsed low mid-frame with 2 beats buffered -> tvalid=0 immediately (asynchronous), counters 0, FSM=IDLE; next frame delivered intact.
REQ-035 ib_empty=1 with tready toggling -> ib_rd never asserts, tvalid stays 0.
